// File: rtl/cpu_dmem_ctrl_pkg.sv
// Shared types for the CPU data-memory controller: FSM state encoding and
// the word-alignment helper.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } dmem_state_t;

  localparam logic [1:0] DMEM_ALIGN_MASK = 2'b11;

  function automatic logic dmem_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb & DMEM_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/cpu_dmem_ctrl_if.sv
// Shared memory bus seen by the data-memory controller (master) and the
// arbiter/memory side (slave).
interface cpu_dmem_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);

  logic              bus_req;
  logic              bus_gnt;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_gnt, bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_gnt, bus_rdata, bus_ack
  );

endinterface

// File: rtl/dmem_timeout_ctr.sv
// Clear/enable cycle counter; tc is high while the count sits at TIMEOUT-1,
// i.e. on the last cycle the controller may still wait for an ack.
module dmem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en && !tc) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tc = (cnt_reg == LAST);

endmodule

// File: rtl/cpu_dmem_ctrl.sv
// Data-memory controller: takes one load/store from the memory stage, wins the
// shared bus, performs the access and stalls the pipeline until it completes.
module cpu_dmem_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_re,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_stall,
  output logic                mem_done,
  output logic                mem_err,
  cpu_dmem_ctrl_if.master     bus
);

  dmem_state_t state_reg;
  logic        ctr_clr;
  logic        ctr_en;
  logic        ctr_tc;

  // The counter only runs in WAIT, so it is always fresh on the first WAIT cycle.
  assign ctr_clr = (state_reg != WAIT);
  assign ctr_en  = (state_reg == WAIT);

  dmem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .tc    (ctr_tc)
  );

  assign mem_stall = ((state_reg == IDLE) && (mem_re || mem_we)) ||
                     (state_reg == REQ) || (state_reg == WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      mem_rdata     <= '0;
      mem_done      <= 1'b0;
      mem_err       <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (mem_re || mem_we) begin
            bus.bus_addr  <= mem_addr;
            bus.bus_wdata <= mem_wdata;
            // Bad requests complete locally and never touch the bus.
            if (dmem_misaligned(mem_addr[1:0]) || (mem_re && mem_we)) begin
              state_reg <= DONE;
              mem_done  <= 1'b1;
              mem_err   <= 1'b1;
            end else begin
              state_reg   <= REQ;
              bus.bus_req <= 1'b1;
              bus.bus_we  <= mem_we;
            end
          end
        end
        REQ: begin
          if (bus.bus_gnt) begin
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          // An ack on the terminal-count cycle still completes cleanly.
          if (bus.bus_ack) begin
            state_reg   <= DONE;
            mem_done    <= 1'b1;
            mem_err     <= 1'b0;
            mem_rdata   <= bus.bus_we ? '0 : bus.bus_rdata;
            bus.bus_req <= 1'b0;
            bus.bus_we  <= 1'b0;
          end else if (ctr_tc) begin
            state_reg   <= DONE;
            mem_done    <= 1'b1;
            mem_err     <= 1'b1;
            mem_rdata   <= '0;
            bus.bus_req <= 1'b0;
            bus.bus_we  <= 1'b0;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          mem_done  <= 1'b0;
          mem_err   <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_dmem_ctrl.sv
// Directed bench for cpu_dmem_ctrl: hand-computed expectations checked with
// immediate assertions, one step per clock cycle.
module tb_cpu_dmem_ctrl;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk;
  logic              rst_n;
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_stall;
  logic              mem_done;
  logic              mem_err;

  int checks = 0;
  int errors = 0;

  cpu_dmem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  cpu_dmem_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_stall (mem_stall),
    .mem_done  (mem_done),
    .mem_err   (mem_err),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench did not terminate");
  end

  initial begin
    rst_n = 1'b0; mem_re = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    bus.bus_gnt = 1'b0; bus.bus_ack = 1'b0; bus.bus_rdata = '0;
    @(posedge clk); #2;
    check("rst_done",   32'(mem_done),      32'h0);
    check("rst_err",    32'(mem_err),       32'h0);
    check("rst_rdata",  mem_rdata,          32'h0);
    check("rst_stall",  32'(mem_stall),     32'h0);
    check("rst_req",    32'(bus.bus_req),   32'h0);
    check("rst_we",     32'(bus.bus_we),    32'h0);
    check("rst_addr",   32'(bus.bus_addr),  32'h0);
    check("rst_wdata",  bus.bus_wdata,      32'h0);
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    tick();
    $display("txn reset released");

    // Load with immediate grant.
    mem_re = 1'b1; mem_addr = 16'h0010; #1;
    check("ld_c0_stall", 32'(mem_stall), 32'h1);
    check("ld_c0_req",   32'(bus.bus_req), 32'h0);
    tick();
    bus.bus_gnt = 1'b1; #1;
    check("ld_c1_req",   32'(bus.bus_req), 32'h1);
    check("ld_c1_stall", 32'(mem_stall), 32'h1);
    check("ld_c1_addr",  32'(bus.bus_addr), 32'h0010);
    check("ld_c1_we",    32'(bus.bus_we), 32'h0);
    tick();
    bus.bus_gnt = 1'b0; bus.bus_ack = 1'b1; bus.bus_rdata = 32'hDEADBEEF; #1;
    check("ld_c2_stall", 32'(mem_stall), 32'h1);
    check("ld_c2_done",  32'(mem_done), 32'h0);
    tick();
    bus.bus_ack = 1'b0; mem_re = 1'b0; #1;
    check("ld_c3_done",  32'(mem_done), 32'h1);
    check("ld_c3_err",   32'(mem_err), 32'h0);
    check("ld_c3_rdata", mem_rdata, 32'hDEADBEEF);
    check("ld_c3_stall", 32'(mem_stall), 32'h0);
    tick();
    check("ld_c4_done",  32'(mem_done), 32'h0);
    $display("txn load 0x0010 rdata=0x%08h", mem_rdata);

    // Misaligned load.
    mem_re = 1'b1; mem_addr = 16'h0013; #1;
    check("mis_c0_stall", 32'(mem_stall), 32'h1);
    tick();
    mem_re = 1'b0; #1;
    check("mis_c1_done",  32'(mem_done), 32'h1);
    check("mis_c1_err",   32'(mem_err), 32'h1);
    check("mis_c1_req",   32'(bus.bus_req), 32'h0);
    check("mis_c1_rdata", mem_rdata, 32'hDEADBEEF);
    check("mis_c1_stall", 32'(mem_stall), 32'h0);
    tick();
    check("mis_c2_done",  32'(mem_done), 32'h0);
    check("mis_c2_req",   32'(bus.bus_req), 32'h0);
    $display("txn misaligned 0x0013 err flagged");

    // Conflicting load+store.
    mem_re = 1'b1; mem_we = 1'b1; mem_addr = 16'h0020; mem_wdata = 32'h55AA55AA; #1;
    check("cf_c0_stall", 32'(mem_stall), 32'h1);
    tick();
    mem_re = 1'b0; mem_we = 1'b0; #1;
    check("cf_c1_done",  32'(mem_done), 32'h1);
    check("cf_c1_err",   32'(mem_err), 32'h1);
    check("cf_c1_req",   32'(bus.bus_req), 32'h0);
    check("cf_c1_we",    32'(bus.bus_we), 32'h0);
    tick();
    check("cf_c2_done",  32'(mem_done), 32'h0);
    $display("txn conflict re&we err flagged");

    // Store with grant held off for 5 cycles; a stray ack in REQ is ignored.
    mem_we = 1'b1; mem_addr = 16'h0104; mem_wdata = 32'h12345678; #1;
    check("st_c0_stall", 32'(mem_stall), 32'h1);
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.bus_ack = (i == 0); bus.bus_rdata = 32'hAAAA5555; #1;
      check("st_req",   32'(bus.bus_req), 32'h1);
      check("st_we",    32'(bus.bus_we), 32'h1);
      check("st_addr",  32'(bus.bus_addr), 32'h0104);
      check("st_wdata", bus.bus_wdata, 32'h12345678);
      check("st_stall", 32'(mem_stall), 32'h1);
      check("st_done",  32'(mem_done), 32'h0);
      tick();
    end
    bus.bus_ack = 1'b0; bus.bus_gnt = 1'b1; #1;
    check("st_gnt_req", 32'(bus.bus_req), 32'h1);
    tick();
    bus.bus_gnt = 1'b0; bus.bus_ack = 1'b1; #1;
    check("st_wait_stall", 32'(mem_stall), 32'h1);
    tick();
    bus.bus_ack = 1'b0; mem_we = 1'b0; #1;
    check("st_done_pulse", 32'(mem_done), 32'h1);
    check("st_done_err",   32'(mem_err), 32'h0);
    check("st_done_rdata", mem_rdata, 32'h0);
    check("st_done_req",   32'(bus.bus_req), 32'h0);
    tick();
    check("st_single_done", 32'(mem_done), 32'h0);
    $display("txn store 0x0104 wdata=0x12345678 done");

    // Ack on the last allowed WAIT cycle wins over the timeout.
    mem_re = 1'b1; mem_addr = 16'h0040;
    tick();
    bus.bus_gnt = 1'b1;
    tick();
    bus.bus_gnt = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (i == TIMEOUT - 1) begin
        bus.bus_ack = 1'b1; bus.bus_rdata = 32'hCAFEF00D;
      end
      #1;
      check("late_stall", 32'(mem_stall), 32'h1);
      check("late_done",  32'(mem_done), 32'h0);
      tick();
    end
    bus.bus_ack = 1'b0; mem_re = 1'b0; #1;
    check("late_done_pulse", 32'(mem_done), 32'h1);
    check("late_err",        32'(mem_err), 32'h0);
    check("late_rdata",      mem_rdata, 32'hCAFEF00D);
    tick();
    $display("txn load 0x0040 ack on final wait cycle rdata=0x%08h", mem_rdata);

    // Timeout; gnt and ack together in REQ must not complete the access.
    mem_re = 1'b1; mem_addr = 16'h0030;
    tick();
    bus.bus_gnt = 1'b1; bus.bus_ack = 1'b1; bus.bus_rdata = 32'h11111111; #1;
    check("to_req", 32'(bus.bus_req), 32'h1);
    tick();
    bus.bus_gnt = 1'b0; bus.bus_ack = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      #1;
      check("to_stall", 32'(mem_stall), 32'h1);
      check("to_done",  32'(mem_done), 32'h0);
      tick();
    end
    mem_re = 1'b0; #1;
    check("to_done_pulse", 32'(mem_done), 32'h1);
    check("to_err",        32'(mem_err), 32'h1);
    check("to_rdata",      mem_rdata, 32'h0);
    check("to_req_drop",   32'(bus.bus_req), 32'h0);
    tick();
    check("to_after_done", 32'(mem_done), 32'h0);
    $display("txn load 0x0030 timed out");

    // Reset in the middle of WAIT.
    mem_re = 1'b1; mem_addr = 16'h0050;
    tick();
    bus.bus_gnt = 1'b1;
    tick();
    bus.bus_gnt = 1'b0; #1;
    check("mr_wait_req", 32'(bus.bus_req), 32'h1);
    #2;
    rst_n = 1'b0; mem_re = 1'b0; #1;
    check("mr_req",   32'(bus.bus_req), 32'h0);
    check("mr_stall", 32'(mem_stall), 32'h0);
    check("mr_done",  32'(mem_done), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    mem_re = 1'b1; mem_addr = 16'h0060;
    tick();
    bus.bus_gnt = 1'b1;
    tick();
    bus.bus_gnt = 1'b0; bus.bus_ack = 1'b1; bus.bus_rdata = 32'h600DF00D;
    tick();
    bus.bus_ack = 1'b0; mem_re = 1'b0; #1;
    check("pr_done",  32'(mem_done), 32'h1);
    check("pr_err",   32'(mem_err), 32'h0);
    check("pr_rdata", mem_rdata, 32'h600DF00D);
    tick();
    $display("txn reset mid-wait then load 0x0060 rdata=0x%08h", mem_rdata);

    // Spurious ack in IDLE.
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'hBAD0BAD0;
    tick();
    bus.bus_ack = 1'b0; #1;
    check("sp_done",  32'(mem_done), 32'h0);
    check("sp_rdata", mem_rdata, 32'h600DF00D);
    check("sp_req",   32'(bus.bus_req), 32'h0);
    $display("txn spurious ack in idle ignored");

    // Back-to-back loads to 0x0000 and 0x0004.
    mem_re = 1'b1; mem_addr = 16'h0000;
    tick();
    bus.bus_gnt = 1'b1;
    tick();
    bus.bus_gnt = 1'b0; bus.bus_ack = 1'b1; bus.bus_rdata = 32'hA0A0A0A0;
    tick();
    bus.bus_ack = 1'b0; mem_addr = 16'h0004; #1;
    check("bb1_done",  32'(mem_done), 32'h1);
    check("bb1_rdata", mem_rdata, 32'hA0A0A0A0);
    check("bb1_stall", 32'(mem_stall), 32'h0);
    tick();
    check("bb_gap_done",  32'(mem_done), 32'h0);
    check("bb_gap_stall", 32'(mem_stall), 32'h1);
    check("bb_gap_req",   32'(bus.bus_req), 32'h0);
    tick();
    bus.bus_gnt = 1'b1; #1;
    check("bb2_req",  32'(bus.bus_req), 32'h1);
    check("bb2_addr", 32'(bus.bus_addr), 32'h0004);
    tick();
    bus.bus_gnt = 1'b0; bus.bus_ack = 1'b1; bus.bus_rdata = 32'hB4B4B4B4;
    tick();
    bus.bus_ack = 1'b0; mem_re = 1'b0; #1;
    check("bb2_done",  32'(mem_done), 32'h1);
    check("bb2_err",   32'(mem_err), 32'h0);
    check("bb2_rdata", mem_rdata, 32'hB4B4B4B4);
    tick();
    check("bb2_after", 32'(mem_done), 32'h0);
    $display("txn back-to-back loads 0x0000/0x0004 done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_dmem_ctrl.md
# cpu_dmem_ctrl

Data-memory controller sitting directly downstream of the CPU memory stage. It accepts one load or store per request from the memory stage, then arbitrates for the shared memory bus that is also used by the VPU, and performs the access. It stalls the pipeline until the access completes, returns load data, and flags misaligned, conflicting or timed-out accesses. There is one outstanding access at a time, with no buffering beyond the latched request.

## Interface
- ADDR_W, 16, byte address width
- DATA_W, 32, data word width; accesses are word-aligned
- TIMEOUT, 16, max cycles in WAIT without bus_ack before error (≥2)

Ports:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  reset, asynchronous, active-low
- mem_re  in  1  load request from memory stage
- mem_we  in  1  store request from memory stage
- mem_addr  in  ADDR_W  byte address
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data, valid when mem_done
- mem_stall  out  1  hold pipeline
- mem_done  out  1  one-cycle completion pulse
- mem_err  out  1  error qualifier, valid with mem_done
- bus_req  out  1  request shared bus
- bus_gnt  in  1  bus granted (from arbiter)
- bus_we  out  1  write strobe
- bus_addr  out  ADDR_W  latched address
- bus_wdata  out  DATA_W  latched store data
- bus_rdata  in  DATA_W  read data, valid with bus_ack
- bus_ack  in  1  one-cycle access-complete pulse

## Operation
- The FSM has four states: IDLE, REQ, WAIT and DONE.
- **IDLE:** when mem_re|mem_we, latch addr, wdata and the op.
  - If mem_addr[1:0]≠0, or mem_re&mem_we: go to DONE with err set. There is no bus activity on this path.
  - Otherwise go to REQ.
- **REQ:** bus_req=1, and bus_addr/bus_we/bus_wdata are driven from the latches. When bus_gnt=1, go to WAIT and clear the timeout counter.
- **WAIT:** bus_req stays 1, so the bus is owned until ack.
  - On bus_ack: capture bus_rdata (loads only; stores capture 0) and go to DONE with err=0.
  - If the counter reaches TIMEOUT-1 without ack: go to DONE with err=1 and rdata=0.
- **DONE:** mem_done=1 and mem_err=err for exactly one cycle, then go to IDLE. Requests present in DONE are ignored; the pipeline advances on this edge.
- mem_stall = (IDLE & (mem_re|mem_we)) | REQ | WAIT. It is combinational and low in DONE.
- Request inputs must stay stable while mem_stall=1. After leaving IDLE the block ignores them.
- bus_gnt outside REQ is ignored. bus_ack outside WAIT is ignored.
- mem_rdata holds its last value until the next capture.

## Timing
- **Reset:** state=IDLE. mem_rdata, mem_done, mem_err, bus_req, bus_we, bus_addr and bus_wdata are all 0. The counter is 0.
- **Reset mid-access:** all outputs drop asynchronously, including bus_req. The access is abandoned.
- **Minimum latency** is 3 stall cycles, with mem_done on the 4th cycle counted from the request in IDLE: request in IDLE at cycle 0, grant at cycle 1, ack at cycle 2, mem_done at cycle 3.
- **Error path:** the stall lasts 1 cycle, and mem_done/mem_err appear in the next cycle.
- **Simultaneous bus_gnt and bus_ack in REQ:** the ack is ignored, and the block waits for a fresh ack in WAIT.
- **bus_ack on the timeout cycle:** the ack wins and err=0.
- **Back-to-back accesses:** the next request is accepted in the IDLE cycle after DONE, giving a 1-cycle bubble.

## Structure
- A shared package cpu_pkg holds:
  - the dmem_state_t enum (IDLE, REQ, WAIT, DONE);
  - the localparam for the alignment mask.
- One natural sub-module is dmem_timeout_ctr: a clear/enable counter with a terminal-count output, parameterised by TIMEOUT.

## Test plan
- **Load, immediate grant:** mem_re with addr 0x0010, gnt at cycle 1, ack with rdata 0xDEADBEEF at cycle 2 → mem_stall high in cycles 0–2, mem_done=1, mem_rdata=0xDEADBEEF, mem_err=0 at cycle 3.
- **Store, delayed grant:** mem_we with addr 0x0104 and wdata 0x12345678, gnt held low for 5 cycles → bus_req high throughout, bus_addr and bus_wdata stable, bus_we=1, single mem_done.
- **Misaligned or conflicting request:** addr 0x0013, or mem_re&mem_we → bus_req never rises, mem_done=1 and mem_err=1 at cycle 1.
- **Timeout:** grant given, ack never arrives → mem_done=1, mem_err=1, mem_rdata=0 after exactly TIMEOUT WAIT cycles. With ack on the final WAIT cycle → err=0.
- **Reset mid-WAIT:** rst_n low → bus_req=0 and mem_stall=0 immediately. After release, a new load completes normally.
- **Back-to-back loads** to 0x0000 and 0x0004 → two mem_done pulses separated by one IDLE cycle. A spurious ack in IDLE is ignored.
